// File: rtl/crc8_frame_checker.sv
// rtl/crc8_frame_checker.sv - length|payload|crc frame parser with CRC-8 check
module crc8_frame_checker #(
    parameter logic [7:0] POLYNOMIAL     = 8'h07,
    parameter logic [7:0] CRC_INIT       = 8'h00,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       payload_valid,
    output logic [7:0] payload_data,
    output logic       frame_done,
    output logic       crc_ok,
    output logic       crc_err,
    output logic       len_err,
    output logic       timeout_err,
    output logic       busy,
    output logic [7:0] err_count
);

    localparam int         GW        = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
    // The gap counter fires on the idle cycle that would bring it to TIMEOUT_CYCLES-1
    localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CYCLES - 2);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CRC     = 2'd2
    } state_t;

    state_t          state;
    logic [7:0]      crc;
    logic [7:0]      remaining;
    logic [GW-1:0]   gap;
    logic [7:0]      crc_next;
    logic [7:0]      crc_first;
    logic            len_bad;

    // One byte of MSB-first CRC-8, fully unrolled
    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] x;
        x = c ^ b;
        for (int i = 0; i < 8; i++) begin
            x = x[7] ? ({x[6:0], 1'b0} ^ POLYNOMIAL) : {x[6:0], 1'b0};
        end
        return x;
    endfunction

    // Next CRC values and length legality for the byte currently on rx_data
    always_comb begin
        crc_next  = crc_step(crc, rx_data);
        crc_first = crc_step(CRC_INIT, rx_data);
        len_bad   = (rx_data == 8'h00) || (rx_data > MAX_LEN_B);
    end

    // Frame FSM with registered outputs, gap timer and saturating error counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            crc           <= 8'h00;
            remaining     <= 8'h00;
            gap           <= '0;
            payload_valid <= 1'b0;
            payload_data  <= 8'h00;
            frame_done    <= 1'b0;
            crc_ok        <= 1'b0;
            crc_err       <= 1'b0;
            len_err       <= 1'b0;
            timeout_err   <= 1'b0;
            busy          <= 1'b0;
            err_count     <= 8'h00;
        end else begin
            payload_valid <= 1'b0;
            frame_done    <= 1'b0;
            crc_ok        <= 1'b0;
            crc_err       <= 1'b0;
            len_err       <= 1'b0;
            timeout_err   <= 1'b0;

            case (state)
                IDLE: begin
                    gap <= '0;
                    if (rx_valid) begin
                        if (len_bad) begin
                            len_err <= 1'b1;
                        end else begin
                            crc       <= crc_first;
                            remaining <= rx_data;
                            busy      <= 1'b1;
                            state     <= PAYLOAD;
                        end
                    end
                end

                PAYLOAD: begin
                    if (rx_valid) begin
                        gap           <= '0;
                        crc           <= crc_next;
                        payload_valid <= 1'b1;
                        payload_data  <= rx_data;
                        remaining     <= remaining - 8'd1;
                        if (remaining == 8'd1) begin
                            state <= CRC;
                        end
                    end else if (gap == GAP_LAST) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        gap         <= '0;
                        state       <= IDLE;
                    end else begin
                        gap <= gap + 1'b1;
                    end
                end

                CRC: begin
                    if (rx_valid) begin
                        gap        <= '0;
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                        if (rx_data == crc) begin
                            crc_ok <= 1'b1;
                        end else begin
                            crc_err <= 1'b1;
                            if (err_count != 8'hFF) begin
                                err_count <= err_count + 8'd1;
                            end
                        end
                    end else if (gap == GAP_LAST) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        gap         <= '0;
                        state       <= IDLE;
                    end else begin
                        gap <= gap + 1'b1;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    gap   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc8_frame_checker.sv
// tb/tb_crc8_frame_checker.sv - directed self-checking bench for crc8_frame_checker
module tb_crc8_frame_checker;

    logic       clk;
    logic       reset;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       payload_valid;
    logic [7:0] payload_data;
    logic       frame_done;
    logic       crc_ok;
    logic       crc_err;
    logic       len_err;
    logic       timeout_err;
    logic       busy;
    logic [7:0] err_count;

    int checks   = 0;
    int failures = 0;

    int pv_cnt   = 0;
    int busy_cnt = 0;
    int err_cnt  = 0;
    int snap_pv;
    int snap_busy;
    int snap_err;

    crc8_frame_checker #(
        .POLYNOMIAL    (8'h07),
        .CRC_INIT      (8'h00),
        .MAX_LEN       (16),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .payload_valid(payload_valid),
        .payload_data (payload_data),
        .frame_done   (frame_done),
        .crc_ok       (crc_ok),
        .crc_err      (crc_err),
        .len_err      (len_err),
        .timeout_err  (timeout_err),
        .busy         (busy),
        .err_count    (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse tallies sampled mid-cycle
    always @(negedge clk) begin
        if (payload_valid) pv_cnt++;
        if (busy) busy_cnt++;
        if (crc_err) err_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tick();
        tick();
        check("rst_pv", payload_valid, 0);
        check("rst_pdata", payload_data, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_errcnt", err_count, 0);
        check("rst_pulses", {frame_done, crc_ok, crc_err, len_err, timeout_err}, 0);
        reset = 1'b0;
        tick();

        // Single good frame 01 31 82
        send(8'h01);
        check("f1_busy_rise", busy, 1);
        check("f1_no_pv_len", payload_valid, 0);
        send(8'h31);
        check("f1_pv", payload_valid, 1);
        check("f1_pdata", payload_data, 8'h31);
        check("f1_no_done", frame_done, 0);
        send(8'h82);
        check("f1_done", frame_done, 1);
        check("f1_ok", crc_ok, 1);
        check("f1_err", crc_err, 0);
        check("f1_busy_fall", busy, 0);
        check("f1_errcnt", err_count, 0);
        tick();
        check("f1_done_pulse", frame_done, 0);
        check("f1_pdata_hold", payload_data, 8'h31);

        // Zero payload byte, good then bad CRC
        send(8'h01);
        send(8'h00);
        check("f2_pdata", payload_data, 8'h00);
        send(8'h15);
        check("f2_ok", crc_ok, 1);
        tick();
        send(8'h01);
        send(8'h00);
        send(8'h16);
        check("f3_done", frame_done, 1);
        check("f3_err", crc_err, 1);
        check("f3_ok", crc_ok, 0);
        check("f3_errcnt", err_count, 1);
        tick();

        // Illegal lengths: 0 and MAX_LEN+1
        snap_pv   = pv_cnt;
        snap_busy = busy_cnt;
        send(8'h00);
        check("len0_err", len_err, 1);
        check("len0_busy", busy, 0);
        tick();
        check("len0_pulse", len_err, 0);
        send(8'h11);
        check("len17_err", len_err, 1);
        check("len17_busy", busy, 0);
        tick();
        check("len_no_pv", pv_cnt - snap_pv, 0);
        check("len_no_busy", busy_cnt - snap_busy, 0);

        // MAX_LEN itself is legal; drop it with a mid-frame reset
        send(8'h10);
        check("len16_busy", busy, 1);
        check("len16_noerr", len_err, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("len16_rst_busy", busy, 0);

        // Timeout after 7 idle cycles in PAYLOAD
        send(8'h02);
        send(8'hAA);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("to_early", timeout_err, 0);
        end
        check("to_busy_held", busy, 1);
        tick();
        check("to_fire", timeout_err, 1);
        check("to_busy_drop", busy, 0);
        check("to_errcnt", err_count, 0);
        tick();
        check("to_pulse", timeout_err, 0);
        send(8'h01);
        send(8'h31);
        send(8'h82);
        check("to_recover_ok", crc_ok, 1);
        tick();

        // Byte arriving on the expiring cycle wins, then timeout in CRC state
        send(8'h02);
        send(8'hAA);
        for (int i = 0; i < 6; i++) tick();
        send(8'hBB);
        check("win_no_to", timeout_err, 0);
        check("win_pv", payload_valid, 1);
        check("win_pdata", payload_data, 8'hBB);
        for (int i = 0; i < 6; i++) tick();
        check("crcst_early", timeout_err, 0);
        tick();
        check("crcst_fire", timeout_err, 1);
        check("crcst_busy", busy, 0);
        check("crcst_nodone", frame_done, 0);
        tick();

        // Back-to-back frames with rx_valid every cycle
        send(8'h01);
        send(8'h31);
        send(8'h82);
        check("b2b_ok1", crc_ok, 1);
        send(8'h01);
        check("b2b_len_accept", frame_done, 0);
        send(8'h00);
        check("b2b_gap_ok", crc_ok, 0);
        check("b2b_pv2", payload_data, 8'h00);
        send(8'h15);
        check("b2b_ok2", crc_ok, 1);
        tick();

        // Reset mid-frame after 02 AA
        send(8'h02);
        send(8'hAA);
        reset = 1'b1;
        tick();
        check("mrst_outs", {payload_valid, frame_done, crc_ok, crc_err, len_err, timeout_err, busy}, 0);
        check("mrst_pdata", payload_data, 8'h00);
        check("mrst_errcnt", err_count, 0);
        reset = 1'b0;
        tick();
        check("mrst_idle_pv", payload_valid, 0);
        send(8'h01);
        send(8'h31);
        send(8'h82);
        check("mrst_ok", crc_ok, 1);
        tick();

        // Saturation of err_count over 256 bad frames
        snap_err = err_cnt;
        for (int i = 0; i < 255; i++) begin
            send(8'h01);
            send(8'h00);
            send(8'h16);
        end
        check("sat_255", err_count, 8'hFF);
        send(8'h01);
        send(8'h00);
        send(8'h16);
        check("sat_err_pulse", crc_err, 1);
        check("sat_hold", err_count, 8'hFF);
        tick();
        check("sat_pulses", err_cnt - snap_err, 256);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
